t9990_palette: RTL

- Consumer of the composed palette address: takes the per-dot 6-bit palette index and backdrop flag from the priority stage, looks up a 64-entry palette RAM, and drives 5:5:5 RGB plus YS to the video output stage.
- Also owns the CPU palette port (P#1 data, R#14 pointer), with byte-sequenced writes and handshaked reads.

---
 rtl/t9990_pkg.sv | 40 ++++
 rtl/t9990_palette_ram.sv | 31 +++
 rtl/t9990_palette.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/t9990_pkg.sv
// Shared types for the T9990 palette block: pointer component encoding, RAM word
// layout and CPU read sequencer states.
package t9990_pkg;

  localparam int unsigned PLT_ADDR_W = 6;

  typedef enum logic [1:0] {
    CompR   = 2'd0,
    CompG   = 2'd1,
    CompB   = 2'd2,
    CompInv = 2'd3
  } plt_comp_t;

  typedef struct packed {
    logic       ys;
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } plt_word_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StData
  } rd_state_e;

  // CPU-visible byte for one component of a stored entry.
  function automatic logic [7:0] plt_byte(input plt_word_t w, input plt_comp_t c);
    logic [7:0] b;
    b = 8'h00;
    case (c)
      CompR:   b = {w.ys, 2'b00, w.r};
      CompG:   b = {3'b000, w.g};
      CompB:   b = {3'b000, w.b};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/t9990_palette_ram.sv
// 64x16 palette storage: one write port, one synchronous read port,
// read-before-write on address collision, no reset.
module t9990_palette_ram
  import t9990_pkg::*;
#(
  parameter int unsigned Depth = 64
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [PLT_ADDR_W-1:0] waddr_i,
  input  plt_word_t             wdata_i,
  input  logic                  re_i,
  input  logic [PLT_ADDR_W-1:0] raddr_i,
  output plt_word_t             rdata_o
);

  plt_word_t mem_q [Depth];
  plt_word_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/t9990_palette.sv
// Palette lookup: 2-strobe video pipeline from PA to 5:5:5 RGB + YS, plus the CPU
// palette port with byte-sequenced writes and a handshaked read sequencer.
module t9990_palette
  import t9990_pkg::*;
#(
  parameter int unsigned PLT_ENTRIES = 64,
  parameter logic [14:0] RST_RGB     = 15'h0000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       DCLK_EN,
  input  logic [5:0] PA,
  input  logic       PRI,
  input  logic       PTR_WR,
  input  logic [7:0] PTR_DATA,
  input  logic       PLT_WR,
  input  logic [7:0] PLT_WDATA,
  input  logic       PLT_RD_REQ,
  output logic [7:0] PLT_RDATA,
  output logic       PLT_RD_ACK,
  input  logic       INC_INH,
  output logic [4:0] R_OUT,
  output logic [4:0] G_OUT,
  output logic [4:0] B_OUT,
  output logic       YS_OUT,
  output logic       TRANS_OUT
);

  logic [5:0] ptr_entry_q, ptr_entry_d;
  plt_comp_t  ptr_comp_q, ptr_comp_d;
  logic [1:0] comp_inc;
  logic [5:0] hold_r_q, hold_r_d;
  logic [4:0] hold_g_q, hold_g_d;
  rd_state_e  rd_state_q, rd_state_d;
  logic [7:0] rdata_q;

  logic       wr_acc, rd_ack, cpu_issue, commit;
  logic       ram_re;
  logic [5:0] ram_raddr;
  plt_word_t  ram_wdata, ram_rdata;

  logic       pri_q, vid_cap_q;
  plt_word_t  vid_word_q;
  logic [4:0] r_q, g_q, b_q;
  logic       ys_q, trans_q;

  logic       unused_bits;
  assign unused_bits = ^PLT_WDATA[6:5];

  // PTR_WR overrides everything; a write landing in DATA forces a re-read so the
  // returned byte reflects the pointer after that write.
  assign wr_acc    = PLT_WR & ~PTR_WR;
  assign rd_ack    = (rd_state_q == StData) & ~PTR_WR & ~PLT_WR;
  assign cpu_issue = (rd_state_q == StWait) & ~DCLK_EN & ~PTR_WR & ~PLT_WR;
  assign commit    = wr_acc & (ptr_comp_q == CompB);

  // Video owns the read port on strobe cycles; CPU reads only use idle cycles.
  assign ram_re    = DCLK_EN | cpu_issue;
  assign ram_raddr = DCLK_EN ? PA : ptr_entry_q;
  assign ram_wdata = {hold_r_q, hold_g_q, PLT_WDATA[4:0]};

  t9990_palette_ram #(
    .Depth (PLT_ENTRIES)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (commit),
    .waddr_i (ptr_entry_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign comp_inc = ptr_comp_q + 2'd1;

  always_comb begin
    ptr_entry_d = ptr_entry_q;
    ptr_comp_d  = ptr_comp_q;
    hold_r_d    = hold_r_q;
    hold_g_d    = hold_g_q;
    if (PTR_WR) begin
      ptr_entry_d = PTR_DATA[7:2];
      ptr_comp_d  = plt_comp_t'(PTR_DATA[1:0]);
    end else if (wr_acc || rd_ack) begin
      if (ptr_comp_q == CompInv || (!INC_INH && ptr_comp_q == CompB)) begin
        ptr_entry_d = ptr_entry_q + 6'd1;
        ptr_comp_d  = CompR;
      end else if (!INC_INH) begin
        ptr_comp_d = plt_comp_t'(comp_inc);
      end
    end
    if (wr_acc) begin
      case (ptr_comp_q)
        CompR:   hold_r_d = {PLT_WDATA[7], PLT_WDATA[4:0]};
        CompG:   hold_g_d = PLT_WDATA[4:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      StIdle: if (PLT_RD_REQ) rd_state_d = StWait;
      StWait: begin
        if (PTR_WR)         rd_state_d = StIdle;
        else if (cpu_issue) rd_state_d = StData;
      end
      StData: begin
        if (PTR_WR)      rd_state_d = StIdle;
        else if (PLT_WR) rd_state_d = StWait;
        else             rd_state_d = StIdle;
      end
      default: rd_state_d = StIdle;
    endcase
  end

  assign PLT_RD_ACK = rd_ack;
  assign PLT_RDATA  = rd_ack ? plt_byte(ram_rdata, ptr_comp_q) : rdata_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_entry_q <= '0;
      ptr_comp_q  <= CompR;
      hold_r_q    <= '0;
      hold_g_q    <= '0;
      rd_state_q  <= StIdle;
      rdata_q     <= '0;
    end else begin
      ptr_entry_q <= ptr_entry_d;
      ptr_comp_q  <= ptr_comp_d;
      hold_r_q    <= hold_r_d;
      hold_g_q    <= hold_g_d;
      rd_state_q  <= rd_state_d;
      rdata_q     <= PLT_RDATA;
    end
  end

  // The word read on a strobe is parked the cycle after, before any CPU read can
  // reuse the RAM output, and is presented on the next strobe.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pri_q      <= 1'b1;
      vid_cap_q  <= 1'b0;
      vid_word_q <= {1'b0, RST_RGB};
      r_q        <= RST_RGB[14:10];
      g_q        <= RST_RGB[9:5];
      b_q        <= RST_RGB[4:0];
      ys_q       <= 1'b0;
      trans_q    <= 1'b1;
    end else begin
      vid_cap_q <= DCLK_EN;
      if (vid_cap_q) begin
        vid_word_q <= ram_rdata;
      end
      if (DCLK_EN) begin
        pri_q   <= PRI;
        trans_q <= pri_q;
        r_q     <= vid_word_q.r;
        g_q     <= vid_word_q.g;
        b_q     <= vid_word_q.b;
        ys_q    <= vid_word_q.ys;
      end
    end
  end

  assign R_OUT     = r_q;
  assign G_OUT     = g_q;
  assign B_OUT     = b_q;
  assign YS_OUT    = ys_q;
  assign TRANS_OUT = trans_q;

endmodule
